// File: rtl/clock_divider_prog.sv
// Programmable clock divider / strobe generator on the 120 kHz system clock.
// Ratio H gives a square wave of period 2*(H+1) or a strobe every H+1 cycles.
//
// Ports:
//   clk_120kHz : system clock, rising edge
//   rstn       : asynchronous active-low reset
//   en         : count enable (low = pause, hold state)
//   sclr       : synchronous clear of count and output phase
//   load       : one-cycle request to capture div_val
//   div_val    : requested ratio value H
//   clk_out    : divided output (registered)
//   tick       : one-cycle pulse on each clk_out rise (registered)
//   pend       : captured ratio waiting for the next period boundary
module clock_divider_prog #(
   parameter int                CNT_W        = 13,
   parameter logic [CNT_W-1:0]  DEFAULT_HALF = CNT_W'(4999),
   parameter bit                PULSE_MODE   = 1'b0
) (
   input  logic             clk_120kHz,
   input  logic             rstn,
   input  logic             en,
   input  logic             sclr,
   input  logic             load,
   input  logic [CNT_W-1:0] div_val,
   output logic             clk_out,
   output logic             tick,
   output logic             pend
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] h_r;
   logic [CNT_W-1:0] shadow;
   logic             term;
   logic             term_eff;
   logic             apply_now;

   assign term      = en && (cnt == h_r);
   // sclr wins over the terminal action, so no ratio swap on a cleared edge
   assign term_eff  = term && !sclr;
   // while paused there is no period in flight, so a load takes effect at once
   assign apply_now = load && !en;

   always_ff @(posedge clk_120kHz or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (sclr || apply_now || term) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_120kHz or negedge rstn) begin
      if (!rstn) begin
         h_r    <= DEFAULT_HALF;
         shadow <= DEFAULT_HALF;
         pend   <= 1'b0;
      end else begin
         if (load) begin
            shadow <= div_val;
         end
         // old shadow is applied even when a new load lands on the same edge
         if (apply_now) begin
            h_r <= div_val;
         end else if (term_eff && pend) begin
            h_r <= shadow;
         end
         if (load && en) begin
            pend <= 1'b1;
         end else if (term_eff || apply_now) begin
            pend <= 1'b0;
         end
      end
   end

   generate
      if (PULSE_MODE) begin : g_pulse
         always_ff @(posedge clk_120kHz or negedge rstn) begin
            if (!rstn) begin
               clk_out <= 1'b0;
               tick    <= 1'b0;
            end else if (sclr) begin
               clk_out <= 1'b0;
               tick    <= 1'b0;
            end else begin
               clk_out <= term;
               tick    <= term;
            end
         end
      end else begin : g_toggle
         always_ff @(posedge clk_120kHz or negedge rstn) begin
            if (!rstn) begin
               clk_out <= 1'b0;
               tick    <= 1'b0;
            end else if (sclr) begin
               clk_out <= 1'b0;
               tick    <= 1'b0;
            end else if (term) begin
               clk_out <= ~clk_out;
               tick    <= ~clk_out;
            end else begin
               tick    <= 1'b0;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed testbench for clock_divider_prog.
// Toggle build with default ratio plus a pulse build sharing the same inputs.
module tb_clock_divider_prog;

   logic        clk_120kHz = 1'b0;
   logic        rstn = 1'b0;
   logic        en = 1'b0;
   logic        sclr = 1'b0;
   logic        load = 1'b0;
   logic [12:0] div_val = '0;
   logic        t_clk, t_tick, t_pend;
   logic        p_clk, p_tick, p_pend;
   int          total = 0;
   int          bad = 0;

   always #5 clk_120kHz = ~clk_120kHz;

   clock_divider_prog u_tog (
      .clk_120kHz(clk_120kHz), .rstn(rstn), .en(en), .sclr(sclr),
      .load(load), .div_val(div_val),
      .clk_out(t_clk), .tick(t_tick), .pend(t_pend)
   );

   clock_divider_prog #(.DEFAULT_HALF(13'd4), .PULSE_MODE(1'b1)) u_pul (
      .clk_120kHz(clk_120kHz), .rstn(rstn), .en(en), .sclr(sclr),
      .load(load), .div_val(div_val),
      .clk_out(p_clk), .tick(p_tick), .pend(p_pend)
   );

   task automatic clk_n(input int n);
      repeat (n) @(posedge clk_120kHz);
      #1;
   endtask

   // paused load with clear: ratio h applied, cnt=0, clk_out=0, then run
   task automatic prep(input logic [12:0] h);
      en = 1'b0; sclr = 1'b1; load = 1'b1; div_val = h;
      clk_n(1);
      sclr = 1'b0; load = 1'b0; en = 1'b1;
   endtask

   task automatic test_reset;
      #3;
      total++;
      if ({t_clk, t_tick, t_pend} !== 3'b000) begin
         bad++;
         $display("FAIL rst_tog: got %b want 000", {t_clk, t_tick, t_pend});
      end
      clk_n(2);
      total++;
      if ({p_clk, p_tick, p_pend} !== 3'b000) begin
         bad++;
         $display("FAIL rst_pul: got %b want 000", {p_clk, p_tick, p_pend});
      end
   endtask

   task automatic test_default;
      int nt = 0, first = 0, second = 0, pt = 0;
      rstn = 1'b1; en = 1'b1;
      for (int k = 1; k <= 15000; k++) begin
         clk_n(1);
         if (t_tick) begin
            nt++;
            if (nt == 1) first = k;
            if (nt == 2) second = k;
         end
         if (p_tick) pt++;
         if (k == 4999 || k == 5000 || k == 10000 || k == 15000) begin
            total++;
            if (t_clk !== (k == 4999 || k == 10000 ? 1'b0 : 1'b1)) begin
               bad++;
               $display("FAIL def_clk@%0d: got %b", k, t_clk);
            end
         end
      end
      total++;
      if (nt !== 2 || first !== 5000 || second !== 15000) begin
         bad++;
         $display("FAIL def_tick: got n=%0d at %0d,%0d want 2 at 5000,15000",
                  nt, first, second);
      end
      total++;
      if (pt !== 3000) begin
         bad++;
         $display("FAIL pul_def: got %0d strobes want 3000", pt);
      end
   endtask

   task automatic test_load_idle;
      int nt = 0, pt = 0;
      en = 1'b0; load = 1'b1; div_val = 13'd2;
      clk_n(1);
      load = 1'b0;
      total++;
      if (t_pend !== 1'b0 || t_clk !== 1'b1) begin
         bad++;
         $display("FAIL idle_load: pend=%b clk=%b want 0,1", t_pend, t_clk);
      end
      en = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         clk_n(1);
         if (t_tick) nt++;
         if (p_tick) pt++;
         if (k % 3 == 0) begin
            total++;
            if (t_clk !== (k % 6 == 0) || t_tick !== (k % 6 == 0)) begin
               bad++;
               $display("FAIL idle_per@%0d: clk=%b tick=%b", k, t_clk, t_tick);
            end
         end
      end
      total++;
      if (nt !== 2 || pt !== 4) begin
         bad++;
         $display("FAIL idle_cnt: ticks=%0d strobes=%0d want 2,4", nt, pt);
      end
   endtask

   task automatic test_load_running;
      prep(13'd9);
      for (int k = 1; k <= 18; k++) begin
         if (k == 5) begin load = 1'b1; div_val = 13'd3; end
         clk_n(1);
         load = 1'b0;
         if (k == 5 || k == 9) begin
            total++;
            if (t_pend !== 1'b1 || t_clk !== 1'b0) begin
               bad++;
               $display("FAIL run_pend@%0d: pend=%b clk=%b want 1,0",
                        k, t_pend, t_clk);
            end
         end
         if (k == 10 || k == 18) begin
            total++;
            if ({t_clk, t_tick, t_pend} !== 3'b110) begin
               bad++;
               $display("FAIL run_rise@%0d: got %b want 110",
                        k, {t_clk, t_tick, t_pend});
            end
         end
         if (k == 13 || k == 14 || k == 17) begin
            total++;
            if (t_clk !== (k == 13)) begin
               bad++;
               $display("FAIL run_half@%0d: clk=%b", k, t_clk);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      prep(13'd9);
      for (int k = 1; k <= 20; k++) begin
         if (k == 2) begin load = 1'b1; div_val = 13'd5; end
         if (k == 3) begin load = 1'b1; div_val = 13'd1; end
         if (k == 14) begin load = 1'b1; div_val = 13'd3; end
         clk_n(1);
         load = 1'b0;
         case (k)
            3, 10, 14, 16: begin
               total++;
               if ({t_clk, t_pend} !== (k == 3 ? 2'b01 : k == 10 ? 2'b10 :
                                        k == 14 ? 2'b11 : 2'b00)) begin
                  bad++;
                  $display("FAIL b2b@%0d: clk,pend=%b", k, {t_clk, t_pend});
               end
            end
            11, 12, 19, 20: begin
               total++;
               if (t_clk !== (k == 11 || k == 20)) begin
                  bad++;
                  $display("FAIL b2b_clk@%0d: clk=%b", k, t_clk);
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic test_zero;
      prep(13'd0);
      for (int k = 1; k <= 5; k++) begin
         clk_n(1);
         total++;
         if (t_clk !== k[0] || t_tick !== k[0] || p_clk !== 1'b1 ||
             p_tick !== 1'b1) begin
            bad++;
            $display("FAIL zero@%0d: tog=%b%b pul=%b%b",
                     k, t_clk, t_tick, p_clk, p_tick);
         end
      end
      en = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         clk_n(1);
         total++;
         if ({t_clk, t_tick, p_clk, p_tick} !== 4'b1000) begin
            bad++;
            $display("FAIL zero_pause@%0d: got %b want 1000",
                     k, {t_clk, t_tick, p_clk, p_tick});
         end
      end
   endtask

   task automatic test_pause_sclr;
      prep(13'd9);
      clk_n(6);
      en = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         clk_n(1);
         total++;
         if ({t_clk, t_tick} !== 2'b00) begin
            bad++;
            $display("FAIL pause@%0d: got %b want 00", k, {t_clk, t_tick});
         end
      end
      en = 1'b1;
      clk_n(3);
      total++;
      if (t_clk !== 1'b0) begin
         bad++;
         $display("FAIL pause_hold: clk=%b want 0", t_clk);
      end
      clk_n(1);
      total++;
      if ({t_clk, t_tick} !== 2'b11) begin
         bad++;
         $display("FAIL pause_rise: got %b want 11", {t_clk, t_tick});
      end
      clk_n(3);
      sclr = 1'b1;
      clk_n(1);
      sclr = 1'b0;
      total++;
      if ({t_clk, t_tick} !== 2'b00) begin
         bad++;
         $display("FAIL sclr: got %b want 00", {t_clk, t_tick});
      end
      clk_n(9);
      total++;
      if (t_clk !== 1'b0) begin
         bad++;
         $display("FAIL sclr_early: clk=%b want 0", t_clk);
      end
      clk_n(1);
      total++;
      if ({t_clk, t_tick} !== 2'b11) begin
         bad++;
         $display("FAIL sclr_rise: got %b want 11", {t_clk, t_tick});
      end
   endtask

   task automatic test_async_reset;
      int first = 0;
      load = 1'b1; div_val = 13'd2;
      clk_n(1);
      load = 1'b0;
      total++;
      if ({t_clk, t_pend} !== 2'b11) begin
         bad++;
         $display("FAIL ar_pre: clk,pend=%b want 11", {t_clk, t_pend});
      end
      #2;
      rstn = 1'b0;
      #1;
      total++;
      if ({t_clk, t_tick, t_pend} !== 3'b000) begin
         bad++;
         $display("FAIL ar_async: got %b want 000", {t_clk, t_tick, t_pend});
      end
      #2;
      rstn = 1'b1; en = 1'b1;
      for (int k = 1; k <= 5001; k++) begin
         clk_n(1);
         if (t_tick && first == 0) first = k;
      end
      total++;
      if (first !== 5000) begin
         bad++;
         $display("FAIL ar_period: first rise at %0d want 5000", first);
      end
   endtask

   initial begin
      test_reset;
      test_default;
      test_load_idle;
      test_load_running;
      test_back_to_back;
      test_zero;
      test_pause_sclr;
      test_async_reset;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Programmable, parametrised successor to the fixed 120 kHz -> 12 Hz divider.
- Divides clk_120kHz by a run-time ratio, with glitch-free ratio updates at period boundaries, enable/pause and synchronous clear.
- Offers two output modes: 50% square wave, or single-cycle strobe.
- Feeds game-tick, animation and blink timing from the one system clock, with no extra clock domains.

Parameters:
- CNT_W, 13, width of the counter and of the ratio value.
- DEFAULT_HALF, 4999, ratio value loaded at reset (gives 12 Hz from 120 kHz in toggle mode).
- PULSE_MODE, 0, 0 = toggle (square) output, 1 = one-cycle strobe output.

Ports:
- clk_120kHz  input  1  system clock; all logic on its rising edge.
- rstn  input  1  asynchronous, active-low reset.
- en  input  1  count enable; low = pause and hold state.
- sclr  input  1  synchronous clear of the count and output phase.
- load  input  1  one-cycle request to capture div_val.
- div_val  input  CNT_W  requested ratio value H.
- clk_out  output  1  divided output (registered).
- tick  output  1  one-cycle pulse coincident with each clk_out rising edge (registered).
- pend  output  1  high while a captured ratio waits to be applied.

Behaviour:
- Reset (asynchronous, rstn=0):
  - cnt=0, active ratio H_r=DEFAULT_HALF, shadow=DEFAULT_HALF.
  - clk_out=0, tick=0, pend=0.
- Terminal condition: en=1 and cnt==H_r. On a terminal edge, cnt<=0; otherwise, if en=1, cnt<=cnt+1.
- Toggle mode (PULSE_MODE=0):
  - clk_out inverts on every terminal edge.
  - Period is 2*(H_r+1) cycles; high and low are each H_r+1 cycles.
  - tick=1 for exactly the cycle in which clk_out has just risen.
- Pulse mode (PULSE_MODE=1):
  - clk_out=1 for exactly one cycle after each terminal edge, otherwise 0. Period is H_r+1 cycles.
  - tick equals clk_out.
- First edge: from reset with en=1, clk_out first rises after H_r+1 enabled edges. With the default ratio, that is cycle 5000.
- H_r=0:
  - Every enabled edge is terminal.
  - Toggle mode: clk_out toggles every cycle (divide by 2).
  - Pulse mode: clk_out is held at 1 and tick at 1.
- Ratio load:
  - load=1 writes div_val into the shadow and sets pend=1.
  - On the next terminal edge, H_r<=shadow and pend<=0. The current period always completes with the old ratio.
- load coincident with a terminal edge: the shadow is written, but the old shadow value, if pend was set, is what gets applied. The new value applies at the following terminal edge, and pend stays 1.
- A second load while pend=1 overwrites the shadow; last write wins.
- load while en=0: the ratio is applied immediately.
  - H_r<=div_val, pend stays 0.
  - cnt<=0; clk_out is not changed.
- en=0: cnt, clk_out (toggle mode), H_r and shadow all hold.
  - tick is forced to 0; in pulse mode clk_out is forced to 0.
  - A pending load stays pending until a terminal edge occurs after en returns high.
- sclr=1 (synchronous):
  - cnt<=0, clk_out<=0, tick<=0.
  - H_r, shadow and pend are unaffected.
  - sclr overrides en and the terminal action in the same cycle.
  - A load in the same cycle is still captured into the shadow.
- Asynchronous reset mid-period: all state returns to reset values immediately. A pending ratio is discarded.
- Arithmetic: cnt is CNT_W bits, unsigned. Because cnt resets at cnt==H_r, it never wraps. div_val is unsigned, and every value 0..2^CNT_W-1 is legal.
- Outputs are glitch-free: every output is driven directly from a flop.

Test Plan:
- Default ratio, en=1 from reset, toggle mode:
  - clk_out rises at cycle 5000, falls at 10000, rises at 15000.
  - tick is high only at cycles 5000 and 15000.
- load div_val=2 with en=0, then en=1:
  - pend stays 0, and clk_out toggles every 3 cycles (period 6).
  - tick fires once per 6 cycles.
- H_r=9 running, load div_val=3 at cnt=4:
  - pend=1, and the current half-period completes at 10 cycles.
  - pend then drops, and subsequent half-periods are 4 cycles.
- div_val=0 applied:
  - Toggle mode: clk_out alternates every cycle.
  - PULSE_MODE=1 build: clk_out and tick stay at constant 1.
  - Dropping en freezes toggle output and forces pulse output to 0.
- en low for 7 cycles mid-count, then sclr pulse:
  - cnt holds during the pause; sclr forces clk_out=0 and cnt=0.
  - The next rise comes H_r+1 cycles after sclr drops, and H_r is unchanged.
- rstn pulsed low with pend=1 and clk_out=1:
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release, the period matches DEFAULT_HALF (the pending ratio is lost).
